// File: rtl/spike_rate_decoder_if.sv
// Result handshake bundle for the spike rate decoder.
// Master produces rate results, slave consumes them.
interface spike_rate_decoder_if #(
    parameter int CNT_W = 8
);
    logic [CNT_W-1:0] rate_out;
    logic             rate_sat;
    logic             rate_valid;
    logic             rate_ready;

    modport master (
        output rate_out,
        output rate_sat,
        output rate_valid,
        input  rate_ready
    );

    modport slave (
        input  rate_out,
        input  rate_sat,
        input  rate_valid,
        output rate_ready
    );
endinterface

// File: rtl/spike_rate_decoder.sv
// Counts output-neuron spikes over back-to-back windows and
// reports each window's count as a rate through valid/ready.
module spike_rate_decoder #(
    parameter int WINDOW_W = 10,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                spike_in,
    input  logic                enable,
    input  logic [WINDOW_W-1:0] window_len,
    spike_rate_decoder_if.master rif,
    output logic                overrun,
    output logic                busy
);

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    state_t              state;
    logic [WINDOW_W-1:0] remain;
    logic [CNT_W-1:0]    cnt;
    logic                sat;
    logic [CNT_W-1:0]    nxt_cnt;
    logic                nxt_sat;

    // Saturating count including this cycle's sample.
    always_comb begin
        nxt_cnt = cnt;
        nxt_sat = sat;
        if (spike_in) begin
            if (&cnt) nxt_sat = 1'b1;
            else      nxt_cnt = cnt + CNT_W'(1);
        end
    end

    assign busy = (state == COUNT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            remain         <= '0;
            cnt            <= '0;
            sat            <= 1'b0;
            rif.rate_out   <= '0;
            rif.rate_sat   <= 1'b0;
            rif.rate_valid <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            if (rif.rate_valid && rif.rate_ready)
                rif.rate_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (enable && window_len != '0) begin
                        remain <= window_len - WINDOW_W'(1);
                        cnt    <= '0;
                        sat    <= 1'b0;
                        state  <= COUNT;
                    end
                end
                COUNT: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (remain != '0) begin
                        remain <= remain - WINDOW_W'(1);
                        cnt    <= nxt_cnt;
                        sat    <= nxt_sat;
                    end else begin
                        rif.rate_out   <= nxt_cnt;
                        rif.rate_sat   <= nxt_sat;
                        rif.rate_valid <= 1'b1;
                        if (rif.rate_valid && !rif.rate_ready)
                            overrun <= 1'b1;
                        // Zero-gap restart with the freshly sampled length.
                        if (window_len != '0) begin
                            remain <= window_len - WINDOW_W'(1);
                            cnt    <= '0;
                            sat    <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Randomized bench for spike_rate_decoder against a
// window-sum reference model.
module tb_spike_rate_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       spike_in;
    logic       enable;
    logic [9:0] window_len;
    logic       overrun;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    spike_rate_decoder_if #(.CNT_W(8)) rif ();

    spike_rate_decoder #(.WINDOW_W(10), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spike_in   (spike_in),
        .enable     (enable),
        .window_len (window_len),
        .rif        (rif),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference model: a window is a list of samples whose plain
    // integer sum is clamped when the window closes.
    bit       m_active;
    int       m_len;
    int       m_n;
    int       m_sum;
    bit [7:0] m_out;
    bit       m_sat;
    bit       m_valid;
    bit       m_ovr;

    function automatic logic [11:0] exp_vec();
        return {m_out, m_sat, m_valid, m_ovr, m_active};
    endfunction

    wire [11:0] obs = {rif.rate_out, rif.rate_sat, rif.rate_valid,
                       overrun, busy};

    task automatic tick();
        bit nv;
        if (!rst_n) begin
            m_active = 0; m_len = 0; m_n = 0; m_sum = 0;
            m_out = 0; m_sat = 0; m_valid = 0; m_ovr = 0;
        end else begin
            nv = m_valid && !rif.rate_ready;
            if (!m_active) begin
                if (enable && window_len != 0) begin
                    m_active = 1; m_len = window_len;
                    m_n = 0; m_sum = 0;
                end
            end else if (!enable) begin
                m_active = 0;
            end else begin
                m_n++;
                m_sum += int'(spike_in);
                if (m_n == m_len) begin
                    m_out = (m_sum > 255) ? 8'd255 : 8'(m_sum);
                    m_sat = (m_sum > 255);
                    if (m_valid && !rif.rate_ready) m_ovr = 1;
                    nv = 1;
                    if (window_len != 0) begin
                        m_len = window_len; m_n = 0; m_sum = 0;
                    end else begin
                        m_active = 0;
                    end
                end
            end
            m_valid = nv;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 0; enable = 0; spike_in = 0;
        window_len = 0; rif.rate_ready = 0;
        tick(); tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; enable = 1; spike_in = 1;
        window_len = 10'd3; rif.rate_ready = 0;
        tick();
        vectors++;
        if (obs !== 12'h000) begin
            miscompares++;
            $display("FAIL reset got %h want %h", obs, 12'h000);
        end
        rst_n = 1;
    endtask

    task automatic test_constant();
        do_reset();
        enable = 1; window_len = 10'd10;
        spike_in = 1; rif.rate_ready = 1;
        tick();
        for (int k = 0; k < 35; k++) begin
            tick();
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL constant cyc %0d got %h want %h",
                         cyc, obs, exp_vec());
            end
            if (k == 9) begin
                vectors++;
                if (rif.rate_valid !== 1'b1 || rif.rate_out !== 8'd10) begin
                    miscompares++;
                    $display("FAIL first_result got v%b r%0d want v1 r10",
                             rif.rate_valid, rif.rate_out);
                end
            end
        end
    endtask

    task automatic test_alternate();
        do_reset();
        enable = 1; window_len = 10'd8;
        spike_in = 0; rif.rate_ready = 1;
        tick();
        for (int k = 0; k < 40; k++) begin
            spike_in = (k % 2 == 0);
            if (k == 12) window_len = 10'd4;
            tick();
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL alternate cyc %0d got %h want %h",
                         cyc, obs, exp_vec());
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        enable = 1; window_len = 10'd300;
        spike_in = 1; rif.rate_ready = 1;
        tick();
        for (int k = 0; k < 605; k++) begin
            spike_in = (k < 300);
            tick();
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL saturate cyc %0d got %h want %h",
                         cyc, obs, exp_vec());
            end
            if (k == 299) begin
                vectors++;
                if ({rif.rate_out, rif.rate_sat} !== {8'd255, 1'b1}) begin
                    miscompares++;
                    $display("FAIL sat_value got %0d/%b want 255/1",
                             rif.rate_out, rif.rate_sat);
                end
            end
        end
    endtask

    task automatic test_overrun();
        bit [4:0] pat1 = 5'b00111;
        do_reset();
        enable = 1; window_len = 10'd5;
        spike_in = 0; rif.rate_ready = 0;
        tick();
        for (int k = 0; k < 15; k++) begin
            spike_in = (k < 5) ? pat1[k] : $urandom_range(0, 1);
            if (k >= 5 && k < 10) spike_in = 1;
            rif.rate_ready = (k == 14);
            tick();
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL overrun cyc %0d got %h want %h",
                         cyc, obs, exp_vec());
            end
            if (k == 9) begin
                vectors++;
                if (obs[11:1] !== {8'd5, 1'b0, 1'b1, 1'b1}) begin
                    miscompares++;
                    $display("FAIL overrun_flag got %h want %h",
                             obs[11:1], {8'd5, 3'b011});
                end
            end
        end
    endtask

    task automatic test_disable();
        do_reset();
        enable = 1; window_len = 10'd6;
        spike_in = 1; rif.rate_ready = 1;
        tick();
        for (int k = 0; k < 16; k++) begin
            enable = !(k == 3);
            spike_in = 1;
            tick();
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL disable cyc %0d got %h want %h",
                         cyc, obs, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        enable = 1; window_len = 10'd2;
        spike_in = 1; rif.rate_ready = 0;
        for (int k = 0; k < 6; k++) tick();
        rst_n = 0;
        tick();
        vectors++;
        if (obs !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_mid got %h want %h", obs, 12'h000);
        end
        rst_n = 1; rif.rate_ready = 1;
        for (int k = 0; k < 10; k++) begin
            spike_in = $urandom_range(0, 1);
            tick();
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL restart cyc %0d got %h want %h",
                         cyc, obs, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            spike_in = $urandom_range(0, 1);
            rif.rate_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) enable = !enable;
            if ($urandom_range(0, 9) == 0)
                window_len = 10'($urandom_range(0, 12));
            if (k == 0) enable = 1;
            tick();
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc %0d got %h want %h",
                         cyc, obs, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_alternate();
        test_saturate();
        test_overrun();
        test_disable();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spike_rate_decoder.md
# spike_rate_decoder

Downstream consumer of the output LIF neuron's spike line. It counts spikes over consecutive, back-to-back windows of programmable length and reports each window's count as a firing rate. Results leave through a valid/ready handshake, so the network's spike output becomes a rate value a host or readout stage can sample. Saturation and overrun are flagged.

## Interface
- WINDOW_W, 10: width of window length; legal window length 1 .. 2^WINDOW_W-1 cycles
- CNT_W, 8: width of spike count / rate result
- clk  in  1  clock; all state changes on posedge
- rst_n  in  1  reset, synchronous, active-low
- spike_in  in  1  spike bit from output neuron, sampled every clk
- enable  in  1  1 = run windows continuously; 0 = idle
- window_len  in  WINDOW_W  window length in cycles, latched at start of each window
- rate_out  out  CNT_W  spike count of most recent completed window
- rate_sat  out  1  count in rate_out saturated (true count > 2^CNT_W-1)
- rate_valid  out  1  rate_out/rate_sat hold an unconsumed result
- rate_ready  in  1  consumer accepts result when rate_valid & rate_ready
- overrun  out  1  sticky: an unconsumed result was overwritten
- busy  out  1  1 while in COUNT state

## Operation
- States: IDLE, COUNT. Reset -> IDLE.
- IDLE: spike_in ignored. If enable=1 and window_len!=0: latch len=window_len, remain<=len-1, cnt<=0, sat<=0, go COUNT. window_len=0 -> stay IDLE.
- COUNT, each cycle:
  - enable=0: discard partial window, go IDLE next edge; no result produced.
  - Otherwise sample spike_in: cnt saturating add (stops at 2^CNT_W-1; sat<=1 on attempted increment past max).
  - remain!=0: remain<=remain-1.
  - remain==0 (final cycle): result = cnt+spike_in (saturating, sat updated the same way) loaded into rate_out/rate_sat; rate_valid<=1. Re-latch window_len immediately: if window_len!=0, restart counter (cnt<=0, sat<=0, remain<=window_len-1), stay COUNT with zero gap cycles; else go IDLE.
- Window of length L covers exactly L consecutive sampled cycles; no spike is lost or double-counted across window boundaries.
- Handshake:
  - rate_valid & rate_ready at an edge: result consumed, rate_valid<=0 unless a new result loads on that same edge (then stays 1 with new data; no overrun).
  - New result loads while rate_valid=1 and rate_ready=0: rate_out/rate_sat overwritten, overrun<=1.
  - rate_out/rate_sat stable while rate_valid=1 and no new result loads.
- overrun cleared only by reset.
- busy = (state==COUNT).

## Timing
- Reset values: rate_out=0, rate_sat=0, rate_valid=0, overrun=0, busy=0; state IDLE; internal counters 0.
- Reset has priority over everything, including mid-window and pending results; pending result is lost.
- enable sampled 1 at edge E0 -> busy=1 after E0; first spike sample at edge E1.
- Window L: samples at E1..EL; rate_valid and rate_out update on edge EL (same edge as final sample). Next window samples from E(L+1).
- enable dropped: sampled 0 at edge Ex -> spike at Ex not counted, busy=0 after Ex.
- window_len changes mid-window have no effect until the next window boundary.
- No combinational path from inputs to outputs.

## Test plan
- Reset, enable=1, window_len=10, spike_in=1 constantly, rate_ready=1 -> rate_valid pulses 1 cycle every 10 cycles, rate_out=10, rate_sat=0, first result on 10th edge after E0.
- window_len=8, spike_in alternating 1/0 starting at E1, rate_ready=1 -> rate_out=4 every window; window_len changed to 4 mid-window -> current window still 8, next results every 4 cycles with rate_out=2.
- window_len=300, spike_in=1 constantly -> rate_out=255, rate_sat=1; following window with spike_in=0 -> rate_out=0, rate_sat=0.
- window_len=5, rate_ready=0, spikes 3 in window 1 and 5 in window 2 -> after window 2 rate_out=5, overrun=1, rate_valid=1; raise rate_ready on the edge a new result loads -> rate_valid stays 1, overrun unchanged.
- enable dropped after 3 of 6 window cycles with spikes -> no rate_valid, busy=0; re-enable -> fresh window counts from 0.
- rst_n=0 mid-window with rate_valid=1 and overrun=1 -> all outputs 0 next edge; operation restarts cleanly when rst_n=1.
